// File: rtl/deconvolution_seq.sv
// Sequential mod-16 deconvolution: recovers x0..x7 from y0..y7 and kernel h0..h7
// by forward substitution, sharing one multiply-accumulate across all taps.
module deconvolution_seq #(
  parameter int W = 4,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] y3,
  input  logic [W-1:0] y4,
  input  logic [W-1:0] y5,
  input  logic [W-1:0] y6,
  input  logic [W-1:0] y7,
  input  logic [W-1:0] h0,
  input  logic [W-1:0] h1,
  input  logic [W-1:0] h2,
  input  logic [W-1:0] h3,
  input  logic [W-1:0] h4,
  input  logic [W-1:0] h5,
  input  logic [W-1:0] h6,
  input  logic [W-1:0] h7,
  output logic [W-1:0] x0,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic [W-1:0] x3,
  output logic [W-1:0] x4,
  output logic [W-1:0] x5,
  output logic [W-1:0] x6,
  output logic [W-1:0] x7,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, INIT, MAC, WRITE, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] yr [N];
  logic [W-1:0] hr [N];
  logic [W-1:0] xr [N];
  logic [2:0]   n;
  logic [2:0]   k;
  logic [2:0]   idx;
  logic [W-1:0] acc;
  logic [W-1:0] prod;

  // Multiplicative inverse mod 16; only odd values have one.
  function automatic logic [W-1:0] inv16(input logic [W-1:0] a);
    case (a)
      4'd1:    inv16 = 4'd1;
      4'd3:    inv16 = 4'd11;
      4'd5:    inv16 = 4'd13;
      4'd7:    inv16 = 4'd7;
      4'd9:    inv16 = 4'd9;
      4'd11:   inv16 = 4'd3;
      4'd13:   inv16 = 4'd5;
      4'd15:   inv16 = 4'd15;
      default: inv16 = 4'd0;
    endcase
  endfunction

  // 4-bit result width truncates the product to mod 16.
  assign idx  = n - k;
  assign prod = hr[k] * xr[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = h0[0] ? INIT : DONE;
      INIT:    state_nxt = (n != 3'd0) ? MAC : WRITE;
      MAC:     if (k == n) state_nxt = WRITE;
      WRITE:   state_nxt = (n == 3'd7) ? DONE : INIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        yr[i] <= '0;
        hr[i] <= '0;
        xr[i] <= '0;
      end
      n   <= '0;
      k   <= '0;
      acc <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          yr[0] <= y0; yr[1] <= y1; yr[2] <= y2; yr[3] <= y3;
          yr[4] <= y4; yr[5] <= y5; yr[6] <= y6; yr[7] <= y7;
          hr[0] <= h0; hr[1] <= h1; hr[2] <= h2; hr[3] <= h3;
          hr[4] <= h4; hr[5] <= h5; hr[6] <= h6; hr[7] <= h7;
          err   <= ~h0[0];
          // An even h0 leaves the previous result visible.
          if (h0[0]) begin
            for (int i = 0; i < N; i++) xr[i] <= '0;
            n <= '0;
          end
        end
        INIT: begin
          acc <= yr[n];
          k   <= 3'd1;
        end
        MAC: begin
          acc <= acc - prod;
          k   <= k + 3'd1;
        end
        WRITE: begin
          xr[n] <= inv16(hr[0]) * acc;
          if (n != 3'd7) n <= n + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign x0   = xr[0];
  assign x1   = xr[1];
  assign x2   = xr[2];
  assign x3   = xr[3];
  assign x4   = xr[4];
  assign x5   = xr[5];
  assign x6   = xr[6];
  assign x7   = xr[7];
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_deconvolution_seq.sv
// Bench for deconvolution_seq: table vectors, random round trips through a
// convolution model, and hand-written reset / ignored-start sequences.
module tb_deconvolution_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] yv [8];
  logic [3:0] hv [8];
  logic [3:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic       busy, done, err;
  logic [31:0] xPacked;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] y;
    logic [31:0] x;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] x;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  vec_t vecs [4];
  exp_t sbq [$];

  always #5 clk = ~clk;

  assign xPacked = {x7, x6, x5, x4, x3, x2, x1, x0};

  deconvolution_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]),
    .y4(yv[4]), .y5(yv[5]), .y6(yv[6]), .y7(yv[7]),
    .h0(hv[0]), .h1(hv[1]), .h2(hv[2]), .h3(hv[3]),
    .h4(hv[4]), .h5(hv[5]), .h6(hv[6]), .h7(hv[7]),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Causal convolution y[n] = sum h[k]*x[n-k], truncated to 4 bits.
  function automatic logic [31:0] convolve(input logic [31:0] h, input logic [31:0] x);
    logic [31:0] y;
    int          s;
    y = '0;
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k <= n; k++) s += int'(h[4*k +: 4]) * int'(x[4*(n-k) +: 4]);
      y[4*n +: 4] = s[3:0];
    end
    return y;
  endfunction

  task automatic driveInputs(input logic [31:0] h, input logic [31:0] y);
    for (int i = 0; i < 8; i++) begin
      hv[i] = h[4*i +: 4];
      yv[i] = y[4*i +: 4];
    end
  endtask

  task automatic applyStimulus(input logic [31:0] h, input logic [31:0] y,
                               input logic [31:0] expX, input logic expErr);
    exp_t e;
    @(negedge clk);
    driveInputs(h, y);
    start = 1'b1;
    e.x   = expX;
    e.err = expErr;
    e.lat = expErr ? 8'd0 : 8'd44;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Negedge index c lies between edges E0+c and E0+c+1.
  task automatic checkOutput(input int pulseAt);
    exp_t e;
    int   c;
    bit   seen;
    seen = 1'b0;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sbq.pop_front();
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("busyAfterAccept", {31'd0, busy}, 32'd1);
        check("errAfterAccept", {31'd0, err}, {31'd0, e.err});
      end
      if (c == pulseAt - 1) begin
        start = 1'b1;
        driveInputs($urandom, $urandom);
      end
      if (c == pulseAt) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("doneLatency", seen ? c : -1, {24'd0, e.lat});
    check("resultX", xPacked, e.x);
    check("resultErr", {31'd0, err}, {31'd0, e.err});
    @(negedge clk);
    check("doneOneCycle", {31'd0, done}, 32'd0);
    check("idleBusy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rx, rh;
    int          sawDone;

    vecs[0] = '{h: 32'h00000013, y: 32'h00000273, x: 32'h00000021, err: 1'b0};
    vecs[1] = '{h: 32'h00000004, y: 32'h12345678, x: 32'h00000021, err: 1'b1};
    vecs[2] = '{h: 32'h0000000F, y: 32'h11111111, x: 32'hFFFFFFFF, err: 1'b0};
    vecs[3] = '{h: 32'h11111111, y: 32'h11111111, x: 32'h00000001, err: 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    driveInputs('0, '0);
    #1;
    check("resetX", xPacked, 32'd0);
    check("resetBusy", {31'd0, busy}, 32'd0);
    check("resetDone", {31'd0, done}, 32'd0);
    check("resetErr", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].h, vecs[i].y, vecs[i].x, vecs[i].err);
      checkOutput(-1);
    end

    for (int i = 0; i < 4; i++) begin
      rx = $urandom;
      rh = $urandom | 32'd1;
      applyStimulus(rh, convolve(rh, rx), rx, 1'b0);
      checkOutput(i == 1 ? 10 : -1);
    end

    // Abort mid-MAC: partial result visible, then async reset clears everything.
    @(negedge clk);
    driveInputs(vecs[0].h, vecs[0].y);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    check("partialX", xPacked, 32'h00000021);
    #2 rst = 1'b1;
    #1;
    check("abortX", xPacked, 32'd0);
    check("abortBusy", {31'd0, busy}, 32'd0);
    check("abortDone", {31'd0, done}, 32'd0);
    check("abortErr", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    check("noDoneAfterAbort", sawDone, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
